// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex display bank: active-low segment patterns
// for the sixteen hex glyphs, the blank pattern and segment bit indices.
package hex_disp_pkg;

   typedef logic [6:0] seg7_t;

   // All segments dark on an active-low board.
   localparam seg7_t SEG_BLANK_AL = 7'h7F;

   // Glyph patterns, bit order {g,f,e,d,c,b,a}, active-low.
   localparam seg7_t SEG_HEX_0 = 7'b1000000;
   localparam seg7_t SEG_HEX_1 = 7'b1111001;
   localparam seg7_t SEG_HEX_2 = 7'b0100100;
   localparam seg7_t SEG_HEX_3 = 7'b0110000;
   localparam seg7_t SEG_HEX_4 = 7'b0011001;
   localparam seg7_t SEG_HEX_5 = 7'b0010010;
   localparam seg7_t SEG_HEX_6 = 7'b0000010;
   localparam seg7_t SEG_HEX_7 = 7'b1111000;
   localparam seg7_t SEG_HEX_8 = 7'b0000000;
   localparam seg7_t SEG_HEX_9 = 7'b0010000;
   localparam seg7_t SEG_HEX_A = 7'b0001000;
   localparam seg7_t SEG_HEX_B = 7'b0000011;
   localparam seg7_t SEG_HEX_C = 7'b1000110;
   localparam seg7_t SEG_HEX_D = 7'b0100001;
   localparam seg7_t SEG_HEX_E = 7'b0000110;
   localparam seg7_t SEG_HEX_F = 7'b0001110;

   // Position of each named segment within a 7-bit digit field.
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

endpackage

// File: rtl/hex7seg_lut.sv
// Combinational nibble to 7-segment decoder, active-low output.
module hex7seg_lut
   import hex_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   seg7_t pattern;

   // Look up the glyph for the nibble.
   always_comb begin
      pattern = SEG_BLANK_AL;
      case (nibble)
         4'h0:    pattern = SEG_HEX_0;
         4'h1:    pattern = SEG_HEX_1;
         4'h2:    pattern = SEG_HEX_2;
         4'h3:    pattern = SEG_HEX_3;
         4'h4:    pattern = SEG_HEX_4;
         4'h5:    pattern = SEG_HEX_5;
         4'h6:    pattern = SEG_HEX_6;
         4'h7:    pattern = SEG_HEX_7;
         4'h8:    pattern = SEG_HEX_8;
         4'h9:    pattern = SEG_HEX_9;
         4'hA:    pattern = SEG_HEX_A;
         4'hB:    pattern = SEG_HEX_B;
         4'hC:    pattern = SEG_HEX_C;
         4'hD:    pattern = SEG_HEX_D;
         4'hE:    pattern = SEG_HEX_E;
         4'hF:    pattern = SEG_HEX_F;
         default: pattern = SEG_BLANK_AL;
      endcase
   end

   // Route table bits to the port by segment name, so a different pin
   // order only needs the index constants changed.
   always_comb begin
      seg        = 7'h00;
      seg[SEG_A] = pattern[0];
      seg[SEG_B] = pattern[1];
      seg[SEG_C] = pattern[2];
      seg[SEG_D] = pattern[3];
      seg[SEG_E] = pattern[4];
      seg[SEG_F] = pattern[5];
      seg[SEG_G] = pattern[6];
   end

endmodule

// File: rtl/hex_display_bank.sv
// Registered bank of NUM_DIGITS hex displays with load/hold handshake,
// leading-zero blanking, per-digit blink and selectable polarity.
module hex_display_bank
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int BLINK_DIV      = 25000000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic                      hold,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic                      blank_lz_en,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   output logic                      load_ack,
   output logic [7*NUM_DIGITS-1:0]   seg
);

   localparam int            CNT_W     = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
   // Blank pattern in the board's polarity, used for the reset value.
   localparam seg7_t         SEG_BLANK = SEG_ACTIVE_LOW ? SEG_BLANK_AL : ~SEG_BLANK_AL;

   logic [4*NUM_DIGITS-1:0] value_q;
   logic                    loaded;
   logic [CNT_W-1:0]        blink_cnt;
   logic                    blink_ph;
   logic                    accept;
   logic [7*NUM_DIGITS-1:0] dec_al;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [7*NUM_DIGITS-1:0] seg_next;

   assign accept = load & ~hold;

   // Capture the display value when a load is accepted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_q <= '0;
         loaded  <= 1'b0;
      end else if (accept) begin
         value_q <= value;
         loaded  <= 1'b1;
      end else begin
         value_q <= value_q;
         loaded  <= loaded;
      end
   end

   // One-cycle acknowledge for every accepted load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         load_ack <= 1'b0;
      end else begin
         load_ack <= accept;
      end
   end

   // Free-running blink prescaler; a load restarts it in the visible phase.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (accept) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (blink_cnt == CNT_LAST) begin
         blink_cnt <= '0;
         blink_ph  <= ~blink_ph;
      end else begin
         blink_cnt <= blink_cnt + CNT_W'(1);
         blink_ph  <= blink_ph;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lut
         hex7seg_lut u_lut (
            .nibble (value_q[4*gi +: 4]),
            .seg    (dec_al[7*gi +: 7])
         );
      end
   endgenerate

   // Walk from the top digit down; a digit is a leading zero while every
   // nibble at or above it is zero. Digit 0 always shows.
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      lz_blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero    = all_zero & (value_q[4*i +: 4] == 4'h0);
         lz_blank[i] = all_zero & (i != 0);
      end
   end

   // Apply blanking precedence (unloaded > leading zero > blink), then polarity.
   always_comb begin
      seg7_t d;
      d        = SEG_BLANK_AL;
      seg_next = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!loaded) begin
            d = SEG_BLANK_AL;
         end else if (blank_lz_en && lz_blank[i]) begin
            d = SEG_BLANK_AL;
         end else if (blink_ph && blink_mask[i]) begin
            d = SEG_BLANK_AL;
         end else begin
            d = dec_al[7*i +: 7];
         end
         seg_next[7*i +: 7] = SEG_ACTIVE_LOW ? d : ~d;
      end
   end

   // Output register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_hex_display_bank.sv
// Scoreboard bench for hex_display_bank: an active-low and an active-high
// instance share stimulus; a reference model pushes per-cycle expectations.
module tb_hex_display_bank;

   localparam int N   = 6;
   localparam int DIV = 4;

   typedef struct packed {
      logic [7*N-1:0] seg;
      logic           ack;
   } exp_t;

   logic           clock;
   logic           reset;
   logic           load;
   logic           hold;
   logic [4*N-1:0] value;
   logic           blank_lz_en;
   logic [N-1:0]   blink_mask;
   logic           load_ack;
   logic [7*N-1:0] seg;
   logic           load_ack_ah;
   logic [7*N-1:0] seg_ah;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // reference model state
   logic [4*N-1:0] m_vq;
   logic           m_loaded;
   int             m_cnt;
   logic           m_ph;

   hex_display_bank #(.NUM_DIGITS(N), .BLINK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clock(clock), .reset(reset), .load(load), .hold(hold), .value(value),
      .blank_lz_en(blank_lz_en), .blink_mask(blink_mask),
      .load_ack(load_ack), .seg(seg)
   );

   hex_display_bank #(.NUM_DIGITS(N), .BLINK_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut_ah (
      .clock(clock), .reset(reset), .load(load), .hold(hold), .value(value),
      .blank_lz_en(blank_lz_en), .blink_mask(blink_mask),
      .load_ack(load_ack_ah), .seg(seg_ah)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [6:0] ref_dec(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [7*N-1:0] ref_seg(input logic [4*N-1:0] vq, input logic ld,
                                              input logic lz, input logic [N-1:0] mask,
                                              input logic ph);
      logic [7*N-1:0] r;
      logic [6:0]     d;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (!ld)                                  d = 7'h7F;
         else if (lz && i > 0 && (vq >> (4*i)) == '0) d = 7'h7F;
         else if (ph && mask[i])                   d = 7'h7F;
         else                                      d = ref_dec(vq[4*i +: 4]);
         r[7*i +: 7] = d;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_vq     = '0;
      m_loaded = 1'b0;
      m_cnt    = 0;
      m_ph     = 1'b0;
      sb.delete();
   endtask

   // Advance one clock, update the model with inputs sampled at the edge,
   // push the output expected after this edge, and settle 1 time unit.
   task automatic step();
      exp_t e;
      logic acc;
      @(posedge clock);
      acc   = load & ~hold;
      e.seg = ref_seg(m_vq, m_loaded, blank_lz_en, blink_mask, m_ph);
      e.ack = acc;
      if (acc) begin
         m_vq = value; m_loaded = 1'b1; m_cnt = 0; m_ph = 1'b0;
      end else if (m_cnt == DIV - 1) begin
         m_cnt = 0; m_ph = ~m_ph;
      end else begin
         m_cnt = m_cnt + 1;
      end
      sb.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      load = 1'b0; hold = 1'b0; value = '0; blank_lz_en = 1'b0; blink_mask = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      model_reset();
      #11;
      n_vec++;
      if (seg !== {N{7'h7F}}) begin
         n_err++; $display("FAIL reset_seg: got %h want %h", seg, {N{7'h7F}});
      end
      n_vec++;
      if (load_ack !== 1'b0) begin
         n_err++; $display("FAIL reset_ack: got %b want 0", load_ack);
      end
      n_vec++;
      if (seg_ah !== '0) begin
         n_err++; $display("FAIL reset_seg_ah: got %h want 0", seg_ah);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         step(); e = sb.pop_front(); n_vec++;
         if (seg !== e.seg || load_ack !== e.ack) begin
            n_err++; $display("FAIL preload_idle: got %h/%b want %h/%b", seg, load_ack, e.seg, e.ack);
         end
      end
   endtask

   task automatic test_load();
      exp_t e;
      value = 24'h12AB0F; blank_lz_en = 1'b0; blink_mask = '0; hold = 1'b0; load = 1'b1;
      step(); e = sb.pop_front(); n_vec++;
      if (seg !== e.seg || load_ack !== e.ack) begin
         n_err++; $display("FAIL load_edge: got %h/%b want %h/%b", seg, load_ack, e.seg, e.ack);
      end
      load = 1'b0;
      step(); e = sb.pop_front(); n_vec++;
      if (seg !== e.seg || load_ack !== e.ack) begin
         n_err++; $display("FAIL load_visible: got %h/%b want %h/%b", seg, load_ack, e.seg, e.ack);
      end
      n_vec++;
      if (seg !== {7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011, 7'b1000000, 7'b0001110}) begin
         n_err++; $display("FAIL load_12AB0F: got %h", seg);
      end
   endtask

   task automatic test_leading_zero();
      exp_t e;
      blank_lz_en = 1'b1; value = 24'h000000; load = 1'b1;
      step(); void'(sb.pop_front());
      load = 1'b0;
      step(); e = sb.pop_front(); n_vec++;
      if (seg !== e.seg || seg !== {{5{7'h7F}}, 7'b1000000}) begin
         n_err++; $display("FAIL lz_zero: got %h want %h", seg, e.seg);
      end
      value = 24'h000A00; load = 1'b1;
      step(); void'(sb.pop_front());
      load = 1'b0;
      step(); e = sb.pop_front(); n_vec++;
      if (seg !== e.seg || seg !== {{3{7'h7F}}, 7'b0001000, 7'b1000000, 7'b1000000}) begin
         n_err++; $display("FAIL lz_000A00: got %h want %h", seg, e.seg);
      end
      blank_lz_en = 1'b0;
      step(); e = sb.pop_front(); n_vec++;
      if (seg !== e.seg) begin
         n_err++; $display("FAIL lz_off: got %h want %h", seg, e.seg);
      end
   endtask

   task automatic test_hold();
      exp_t e;
      hold = 1'b1; load = 1'b1; value = 24'hFFFFFF;
      for (int i = 0; i < 3; i++) begin
         step(); e = sb.pop_front(); n_vec++;
         if (seg !== e.seg || load_ack !== 1'b0) begin
            n_err++; $display("FAIL hold_frozen: got %h/%b want %h/0", seg, load_ack, e.seg);
         end
      end
      hold = 1'b0;
      step(); e = sb.pop_front(); n_vec++;
      if (load_ack !== 1'b1 || seg !== e.seg) begin
         n_err++; $display("FAIL hold_release_ack: got %h/%b want %h/1", seg, load_ack, e.seg);
      end
      load = 1'b0;
      step(); e = sb.pop_front(); n_vec++;
      if (seg !== {N{7'b0001110}}) begin
         n_err++; $display("FAIL hold_release_seg: got %h want %h", seg, {N{7'b0001110}});
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         value = 24'($urandom);
         step(); e = sb.pop_front(); n_vec++;
         if (seg !== e.seg || load_ack !== 1'b1) begin
            n_err++; $display("FAIL b2b_%0d: got %h/%b want %h/1", i, seg, load_ack, e.seg);
         end
      end
      load = 1'b0;
      step(); e = sb.pop_front(); n_vec++;
      if (seg !== e.seg || load_ack !== 1'b0) begin
         n_err++; $display("FAIL b2b_tail: got %h/%b want %h/0", seg, load_ack, e.seg);
      end
   endtask

   task automatic test_blink();
      exp_t e;
      int   blanks;
      blink_mask = 6'b000001; value = 24'h123456; load = 1'b1;
      step(); void'(sb.pop_front());
      load = 1'b0;
      blanks = 0;
      for (int i = 0; i < 17; i++) begin
         step(); e = sb.pop_front(); n_vec++;
         if (seg !== e.seg || seg_ah !== ~e.seg || load_ack !== e.ack) begin
            n_err++; $display("FAIL blink_%0d: got %h/%h want %h", i, seg, seg_ah, e.seg);
         end
         if (seg[6:0] == 7'h7F) blanks++;
      end
      n_vec++;
      if (blanks != 8) begin
         n_err++; $display("FAIL blink_duty: got %0d blank cycles want 8", blanks);
      end
      // wait for a wrap edge, then load on it
      for (int i = 0; i < DIV && m_cnt != DIV - 1; i++) begin
         step(); void'(sb.pop_front());
      end
      value = 24'h654321; load = 1'b1;
      step(); void'(sb.pop_front());
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); e = sb.pop_front(); n_vec++;
         if (seg !== e.seg || seg[6:0] !== 7'b1111001) begin
            n_err++; $display("FAIL blink_wrap_load_%0d: got %h want %h", i, seg, e.seg);
         end
      end
      step(); e = sb.pop_front(); n_vec++;
      if (seg[6:0] !== 7'h7F || seg !== e.seg) begin
         n_err++; $display("FAIL blink_wrap_phase: got %h want %h", seg, e.seg);
      end
      blink_mask = '0;
   endtask

   task automatic test_polarity();
      exp_t e;
      value = 24'h000008; load = 1'b1;
      step(); void'(sb.pop_front());
      load = 1'b0;
      step(); e = sb.pop_front(); n_vec++;
      if (seg_ah[6:0] !== 7'b1111111 || seg_ah !== ~e.seg || load_ack_ah !== 1'b0) begin
         n_err++; $display("FAIL polarity_8: got %h want %h", seg_ah, ~e.seg);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      value = 24'hABCDEF; load = 1'b1;
      step(); void'(sb.pop_front());
      #3 reset = 1'b1;
      #1;
      model_reset();
      n_vec++;
      if (seg !== {N{7'h7F}} || load_ack !== 1'b0 || seg_ah !== '0) begin
         n_err++; $display("FAIL reset_mid: got %h/%b/%h want all blank, ack 0", seg, load_ack, seg_ah);
      end
      load = 1'b0;
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); e = sb.pop_front(); n_vec++;
         if (seg !== e.seg || load_ack !== e.ack) begin
            n_err++; $display("FAIL post_reset_%0d: got %h/%b want %h/%b", i, seg, load_ack, e.seg, e.ack);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_leading_zero();
      test_hold();
      test_back_to_back();
      test_blink();
      test_polarity();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
